// File: rtl/calib_pkg.sv
// Calibration constants for the forward camera model, the control FSM encoding
// and a small saturation helper shared by the projection datapath.
package calib_pkg;

  // Forward rotation Rc and translation Tc as num/shift pairs (value = num / 2^shift)
  localparam int RC_NUM [3][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
  localparam int RC_SH  [3][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
  localparam int TC_NUM [3]    = '{0, 0, 100};
  localparam int TC_SH  [3]    = '{0, 0, 0};

  // Focal lengths as num/shift, principal point as plain integers
  localparam int KK11_NUM = 256;
  localparam int KK11_SH  = 0;
  localparam int KK22_NUM = 256;
  localparam int KK22_SH  = 0;
  localparam int KK13     = 360;
  localparam int KK23     = 254;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFORM,
    S_DIV_X,
    S_DIV_Y,
    S_OUT
  } state_e;

  function automatic logic signed [11:0] sat12(input logic signed [63:0] x);
    if (x > 64'sd2047)       return 12'sd2047;
    else if (x < -64'sd2048) return -12'sd2048;
    else                     return x[11:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle. The start edge also
// performs the first iteration, so done appears exactly WIDTH cycles after start.
module seq_divider #(
  parameter int WIDTH = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic [WIDTH-1:0] rem_in, quo_in;
  logic [WIDTH:0]   trial;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, busy_q, busy_d, step;

  // NOTE: every signal assigned in always_comb gets a default up front so no path leaves it unassigned and infers a latch.
  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    den_d  = den_q;
    neg_d  = neg_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    step   = 1'b0;
    if (start) begin
      rem_in = '0;
      quo_in = dividend[WIDTH-1] ? -dividend : dividend;
      den_d  = divisor[WIDTH-1]  ? -divisor  : divisor;
      neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH - 1);
      step   = 1'b1;
    end else if (busy_q && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      step  = 1'b1;
    end

    // Shift the next dividend bit into the partial remainder and try subtracting
    trial = {rem_in, quo_in[WIDTH-1]} - {1'b0, den_d};
    rem_d = rem_q;
    quo_d = quo_q;
    if (step) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
        quo_d = {quo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done     = busy_q && (cnt_q == '0);
  assign quotient = neg_q ? -quo_q : quo_q;

endmodule

// File: rtl/world_projection.sv
// Projects a world point to saturated pixel coordinates through Rc/Tc and the
// intrinsics, sharing one sequential divider for the u and v quotients.
module world_projection
  import calib_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter int FRAC_BITS = 6,
  parameter int IMG_W     = 720,
  parameter int IMG_H     = 508
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [12:0] worldpt1,
  input  logic signed [12:0] worldpt2,
  input  logic signed [12:0] worldpt3,
  output logic               px_valid,
  input  logic               px_ready,
  output logic signed [11:0] px_x,
  output logic signed [11:0] px_y,
  output logic               in_frame,
  output logic               behind
);

  state_e                  state_q, state_d;
  logic signed [12:0]      world_q [3];
  logic signed [12:0]      world_d [3];
  logic signed [WIDTH-1:0] cam [3];
  logic signed [WIDTH-1:0] nx, ny, u, v;
  logic signed [WIDTH-1:0] cam_z_q, cam_z_d, ny_q, ny_d, qx_q, qx_d;
  logic signed [11:0]      px_x_q, px_x_d, px_y_q, px_y_d;
  logic                    px_valid_q, px_valid_d, in_ready_q, in_ready_d;
  logic                    in_frame_q, in_frame_d, behind_q, behind_d;
  logic                    div_start, div_done;
  logic signed [WIDTH-1:0] div_dividend, div_divisor, div_quo;

  // Camera-frame transform and focal scaling on the latched world point
  always_comb begin
    logic signed [WIDTH-1:0] acc;
    for (int i = 0; i < 3; i++) begin
      acc = (WIDTH'(TC_NUM[i]) <<< FRAC_BITS) >>> TC_SH[i];
      for (int j = 0; j < 3; j++) begin
        acc = acc + (((WIDTH'(RC_NUM[i][j]) * WIDTH'(world_q[j])) <<< FRAC_BITS) >>> RC_SH[i][j]);
      end
      cam[i] = acc;
    end
    nx = (WIDTH'(KK11_NUM) * cam[0]) >>> KK11_SH;
    ny = (WIDTH'(KK22_NUM) * cam[1]) >>> KK22_SH;
  end

  // qy arrives straight from the divider on the cycle it completes
  assign u = qx_q + WIDTH'(KK13);
  assign v = div_quo + WIDTH'(KK23);

  always_comb begin
    state_d      = state_q;
    world_d      = world_q;
    cam_z_d      = cam_z_q;
    ny_d         = ny_q;
    qx_d         = qx_q;
    px_x_d       = px_x_q;
    px_y_d       = px_y_q;
    px_valid_d   = px_valid_q;
    in_ready_d   = in_ready_q;
    in_frame_d   = in_frame_q;
    behind_d     = behind_q;
    div_start    = 1'b0;
    div_dividend = ny_q;
    div_divisor  = cam_z_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          world_d    = '{worldpt1, worldpt2, worldpt3};
          in_ready_d = 1'b0;
          state_d    = S_XFORM;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_XFORM: begin
        cam_z_d = cam[2];
        ny_d    = ny;
        if (cam[2] <= 0) begin
          behind_d   = 1'b1;
          px_x_d     = '0;
          px_y_d     = '0;
          in_frame_d = 1'b0;
          px_valid_d = 1'b1;
          state_d    = S_OUT;
        end else begin
          behind_d     = 1'b0;
          div_start    = 1'b1;
          div_dividend = nx;
          div_divisor  = cam[2];
          state_d      = S_DIV_X;
        end
      end
      S_DIV_X: begin
        if (div_done) begin
          qx_d      = div_quo;
          div_start = 1'b1;
          state_d   = S_DIV_Y;
        end
      end
      S_DIV_Y: begin
        if (div_done) begin
          // Frame test uses the unsaturated coordinates
          in_frame_d = (u >= 0) && (u < WIDTH'(IMG_W)) && (v >= 0) && (v < WIDTH'(IMG_H));
          px_x_d     = sat12(64'(u));
          px_y_d     = sat12(64'(v));
          px_valid_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (px_ready) begin
          px_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      world_q    <= '{default: '0};
      cam_z_q    <= '0;
      ny_q       <= '0;
      qx_q       <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      in_frame_q <= 1'b0;
      behind_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      world_q    <= world_d;
      cam_z_q    <= cam_z_d;
      ny_q       <= ny_d;
      qx_q       <= qx_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_valid_q <= px_valid_d;
      in_ready_q <= in_ready_d;
      in_frame_q <= in_frame_d;
      behind_q   <= behind_d;
    end
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign in_ready = in_ready_q;
  assign px_valid = px_valid_q;
  assign px_x     = px_x_q;
  assign px_y     = px_y_q;
  assign in_frame = in_frame_q;
  assign behind   = behind_q;

endmodule

// File: doc/world_projection.md
# world_projection

Forward camera model for the scanner pipeline: it maps a reconstructed world point (X, Y, Z) back to pixel coordinates using cam = Rc·W + Tc, then u = fx·cam_x/cam_z + cx and v = fy·cam_y/cam_z + cy. It is the inverse of `depth_reconstruction` and is used for reprojection and consistency checks, and to drive overlay rendering. It takes in-stream world points and produces pixel outputs through valid/ready handshakes. A single shared iterative divider computes both quotients.

## Interface
- `WIDTH`, 36: internal signed datapath and divider width.
- `FRAC_BITS`, 6: fractional bits carried through the camera-frame products.
- `IMG_W`, 720: image width in pixels.
- `IMG_H`, 508: image height in pixels.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: world point present.
- `in_ready` out 1: block can accept a point.
- `worldpt1`, `worldpt2`, `worldpt3` in 13 each, signed: world X, Y, Z in integer units.
- `px_valid` out 1: result present.
- `px_ready` in 1: consumer accepts the result.
- `px_x`, `px_y` out 12 each, signed: pixel coordinates, saturated.
- `in_frame` out 1: result lies inside 0..IMG_W-1 × 0..IMG_H-1.
- `behind` out 1: cam_z ≤ 0; projection is invalid.

## Operation
- Reset (asynchronous, `rst_n` low):
  - State goes to IDLE; an in-flight divide is aborted.
  - All outputs are 0, except `in_ready`, which is 1.
- FSM states: IDLE → XFORM → DIV_X → DIV_Y → OUT → IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch the world point and go to XFORM.
- XFORM (1 cycle):
  - Compute cam_i = Σ_j ((Rc_ij_num·w_j·2^FRAC_BITS) >>> Rc_ij_sh) + ((Tc_i_num·2^FRAC_BITS) >>> Tc_i_sh).
  - Form nx = (KK11_num·cam_x) >>> KK11_sh and ny = (KK22_num·cam_y) >>> KK22_sh.
  - All arithmetic is signed, WIDTH bits.
  - If cam_z ≤ 0: set `behind`, set `px_x` = `px_y` = 0, clear `in_frame`, go to OUT.
  - Otherwise start the divider on nx / cam_z and go to DIV_X.
- DIV_X: wait for divider done, latch qx, start ny / cam_z, go to DIV_Y.
- DIV_Y: wait for divider done, latch qy, go to OUT.
- Result formation:
  - Quotients truncate toward zero; remainders are dropped.
  - u = qx + KK13 and v = qy + KK23, where KK13 and KK23 are integer principal-point values.
  - `in_frame` = (0 ≤ u < IMG_W) && (0 ≤ v < IMG_H), evaluated before saturation.
  - `px_x` / `px_y` = u / v saturated to [-2048, 2047].
- OUT:
  - `px_valid` = 1; outputs are held stable until `px_ready`.
  - On the handshake, go to IDLE.
- `in_ready` = 0 in every state except IDLE. There is no overlap or skid buffering.

## Timing
- The accepting edge is cycle 0. XFORM occupies cycle 1.
- Each division takes exactly WIDTH cycles.
- `px_valid` rises at cycle 2·WIDTH+2 (74 at the default), and at cycle 2 for a `behind` result.
- `px_valid` to IDLE: one cycle after `px_ready`. `in_ready` returns on the following cycle.
- `px_ready` held high: throughput is one point per 2·WIDTH+4 cycles.
- `px_ready` low: the block stalls indefinitely in OUT with all outputs stable.
- `rst_n` asserted in any state: outputs clear immediately (asynchronously). Operation resumes in IDLE on the first edge after release.

## Structure
- Package `calib_pkg` holds:
  - the forward Rc (num/shift pairs),
  - Tc (num/shift),
  - KK11/KK22 (num/shift) and KK13/KK23 integer principal point,
  - the FSM state enum.
- Sub-module `seq_divider`: signed restoring divider, one bit per cycle, with `start`/`done` handshake and `WIDTH` parameter, instantiated once and shared by both divisions.

## Test plan
All scenarios compile against a test `calib_pkg` with Rc = identity, Tc = (0, 0, 100), fx = fy = 256, cx = 360, cy = 254.

- World (0, 0, 0) → `px_x` = 360, `px_y` = 254, `in_frame` = 1, `behind` = 0, `px_valid` at cycle 74.
- World (100, −50, 0) → `px_x` = 616, `px_y` = 126, `in_frame` = 1.
- World (0, 0, −100), cam_z = 0 → `behind` = 1, `px_x` = `px_y` = 0, `in_frame` = 0, `px_valid` at cycle 2, divider never started.
- World (1000, 0, 0): u = 2920 → `px_x` = 2047, `in_frame` = 0. World (−1000, 0, 0) → `px_x` = −2048.
- `px_ready` held low for 20 cycles → outputs stable and `in_ready` = 0 throughout. `in_valid` asserted meanwhile is not accepted until after the handshake.
- `rst_n` pulsed low during DIV_X → `px_valid` = 0 and `in_ready` = 1 immediately. The next point then projects correctly with full latency.
